// File: rtl/rvsteel_bus_arbiter.sv
// rvsteel_bus_arbiter: round-robin two-manager to one-subordinate bus arbiter.
// Optional response timeout enabled by defining RVSTEEL_BUS_ARBITER_TIMEOUT_EN.
module rvsteel_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] m0_rw_address,
  output logic [31:0] m0_read_data,
  input  logic        m0_read_request,
  output logic        m0_read_response,
  input  logic [31:0] m0_write_data,
  input  logic [3:0]  m0_write_strobe,
  input  logic        m0_write_request,
  output logic        m0_write_response,
  input  logic [31:0] m1_rw_address,
  output logic [31:0] m1_read_data,
  input  logic        m1_read_request,
  output logic        m1_read_response,
  input  logic [31:0] m1_write_data,
  input  logic [3:0]  m1_write_strobe,
  input  logic        m1_write_request,
  output logic        m1_write_response,
  output logic [31:0] s_rw_address,
  input  logic [31:0] s_read_data,
  output logic        s_read_request,
  input  logic        s_read_response,
  output logic [31:0] s_write_data,
  output logic [3:0]  s_write_strobe,
  output logic        s_write_request,
  input  logic        s_write_response,
  output logic [1:0]  grant,
  output logic        bus_timeout
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_grant;
  logic [1:0] w_grant_nxt;
  logic       r_last;
  logic       w_last_nxt;
  logic       r_is_read;
  logic       w_is_read_nxt;

  logic w_req0;
  logic w_req1;
  logic w_busy;
  logic w_sel0;
  logic w_sel1;
  logic w_s_rsp;
  logic w_tmo;
  logic w_rd;
  logic w_wr;

  assign w_req0  = m0_read_request | m0_write_request;
  assign w_req1  = m1_read_request | m1_write_request;
  assign w_busy  = (r_state == BUSY);
  assign w_sel0  = w_busy & r_grant[0];
  assign w_sel1  = w_busy & r_grant[1];
  assign w_s_rsp = s_read_response | s_write_response;

`ifdef RVSTEEL_BUS_ARBITER_TIMEOUT_EN
  logic [15:0] r_tcnt;

  // Held at zero while idle, so it starts from zero on every BUSY entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tcnt <= '0;
    end else if (!w_busy) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + 16'd1;
    end
  end

  assign w_tmo = w_busy & ~w_s_rsp &
                 (r_tcnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_grant   <= 2'b00;
      r_last    <= 1'b1;
      r_is_read <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_last    <= w_last_nxt;
      r_is_read <= w_is_read_nxt;
    end
  end

  // r_last set means m1 owned the bus last, so m0 wins a tie.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_last_nxt    = r_last;
    w_is_read_nxt = r_is_read;
    unique case (r_state)
      IDLE: begin
        if (w_req0 & (~w_req1 | r_last)) begin
          w_state_nxt   = BUSY;
          w_grant_nxt   = 2'b01;
          w_is_read_nxt = m0_read_request;
        end else if (w_req1) begin
          w_state_nxt   = BUSY;
          w_grant_nxt   = 2'b10;
          w_is_read_nxt = m1_read_request;
        end
      end
      BUSY: begin
        if (w_s_rsp | w_tmo) begin
          w_state_nxt = IDLE;
          w_grant_nxt = 2'b00;
          w_last_nxt  = r_grant[1];
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = 2'b00;
      end
    endcase
  end

  assign w_rd = (w_sel0 & m0_read_request) |
                (w_sel1 & m1_read_request);
  assign w_wr = ((w_sel0 & m0_write_request) |
                 (w_sel1 & m1_write_request)) & ~w_rd;

  assign grant           = r_grant;
  assign s_read_request  = w_rd;
  assign s_write_request = w_wr;

  assign s_rw_address = w_sel0 ? m0_rw_address :
                        w_sel1 ? m1_rw_address : 32'h0;
  assign s_write_data = w_sel0 ? m0_write_data :
                        w_sel1 ? m1_write_data : 32'h0;
  assign s_write_strobe = w_sel0 ? m0_write_strobe :
                          w_sel1 ? m1_write_strobe : 4'h0;

  // A timeout answers with the transaction type latched at grant.
  assign m0_read_response  = w_sel0 &
                             (s_read_response | (w_tmo & r_is_read));
  assign m0_write_response = w_sel0 &
                             (s_write_response | (w_tmo & ~r_is_read));
  assign m1_read_response  = w_sel1 &
                             (s_read_response | (w_tmo & r_is_read));
  assign m1_write_response = w_sel1 &
                             (s_write_response | (w_tmo & ~r_is_read));

  assign m0_read_data = (w_sel0 & ~w_tmo) ? s_read_data : 32'h0;
  assign m1_read_data = (w_sel1 & ~w_tmo) ? s_read_data : 32'h0;

  assign bus_timeout = w_tmo;

endmodule

// File: tb/tb_rvsteel_bus_arbiter.sv
// tb_rvsteel_bus_arbiter: directed and randomized checks of rvsteel_bus_arbiter.
// Timeout scenarios are exercised only when RVSTEEL_BUS_ARBITER_TIMEOUT_EN is set.
`timescale 1ns/1ps
module tb_rvsteel_bus_arbiter;

  localparam int TMO = 8;
`ifdef RVSTEEL_BUS_ARBITER_TIMEOUT_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic [31:0] m0_rw_address, m0_read_data, m0_write_data;
  logic [31:0] m1_rw_address, m1_read_data, m1_write_data;
  logic [3:0]  m0_write_strobe, m1_write_strobe;
  logic        m0_read_request, m0_read_response;
  logic        m0_write_request, m0_write_response;
  logic        m1_read_request, m1_read_response;
  logic        m1_write_request, m1_write_response;
  logic [31:0] s_rw_address, s_write_data;
  logic [3:0]  s_write_strobe;
  logic        s_read_request, s_write_request;
  logic [1:0]  grant;
  logic        bus_timeout;

  logic [31:0] ma [2];
  logic [31:0] md [2];
  logic [3:0]  ms [2];
  logic        mrd [2];
  logic        mwr [2];
  logic        srr, swr;
  logic [31:0] srd;

  assign m0_rw_address    = ma[0];
  assign m0_write_data    = md[0];
  assign m0_write_strobe  = ms[0];
  assign m0_read_request  = mrd[0];
  assign m0_write_request = mwr[0];
  assign m1_rw_address    = ma[1];
  assign m1_write_data    = md[1];
  assign m1_write_strobe  = ms[1];
  assign m1_read_request  = mrd[1];
  assign m1_write_request = mwr[1];

  rvsteel_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .m0_rw_address(m0_rw_address), .m0_read_data(m0_read_data),
    .m0_read_request(m0_read_request), .m0_read_response(m0_read_response),
    .m0_write_data(m0_write_data), .m0_write_strobe(m0_write_strobe),
    .m0_write_request(m0_write_request), .m0_write_response(m0_write_response),
    .m1_rw_address(m1_rw_address), .m1_read_data(m1_read_data),
    .m1_read_request(m1_read_request), .m1_read_response(m1_read_response),
    .m1_write_data(m1_write_data), .m1_write_strobe(m1_write_strobe),
    .m1_write_request(m1_write_request), .m1_write_response(m1_write_response),
    .s_rw_address(s_rw_address), .s_read_data(srd),
    .s_read_request(s_read_request), .s_read_response(srr),
    .s_write_data(s_write_data), .s_write_strobe(s_write_strobe),
    .s_write_request(s_write_request), .s_write_response(swr),
    .grant(grant), .bus_timeout(bus_timeout)
  );

  always #5 clock = ~clock;

  int errs = 0;
  int checks = 0;

  // Transaction-level model: current owner (-1 none), how long it has
  // held the bus, the type it asked for, and who was served last.
  int mo = -1;
  int mage = 0;
  int lat = 0;
  bit mtr = 1'b0;
  bit last_m1 = 1'b1;
  bit done [2];
  bit auto_mode = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic compare();
    int o;
    bit tmo;
    logic [1:0] eg;
    logic [31:0] ea, ed;
    logic [3:0] es;
    bit er, ew;
    o = (reset && mo >= 0) ? mo : -1;
    tmo = TE && o >= 0 && !(srr || swr) && mage == TMO;
    eg = 2'b00; ea = '0; ed = '0; es = '0; er = 1'b0; ew = 1'b0;
    if (o >= 0) begin
      eg = (o == 0) ? 2'b01 : 2'b10;
      ea = ma[o]; ed = md[o]; es = ms[o];
      er = mrd[o];
      ew = mwr[o] && !mrd[o];
    end
    chk("grant", {30'h0, grant}, {30'h0, eg});
    chk("s_addr", s_rw_address, ea);
    chk("s_wdata", s_write_data, ed);
    chk("s_strobe", {28'h0, s_write_strobe}, {28'h0, es});
    chk("s_rreq", {31'h0, s_read_request}, {31'h0, er});
    chk("s_wreq", {31'h0, s_write_request}, {31'h0, ew});
    chk("m0_rresp", {31'h0, m0_read_response},
        {31'h0, o == 0 && (srr || (tmo && mtr))});
    chk("m0_wresp", {31'h0, m0_write_response},
        {31'h0, o == 0 && (swr || (tmo && !mtr))});
    chk("m0_rdata", m0_read_data, (o == 0 && !tmo) ? srd : 32'h0);
    chk("m1_rresp", {31'h0, m1_read_response},
        {31'h0, o == 1 && (srr || (tmo && mtr))});
    chk("m1_wresp", {31'h0, m1_write_response},
        {31'h0, o == 1 && (swr || (tmo && !mtr))});
    chk("m1_rdata", m1_read_data, (o == 1 && !tmo) ? srd : 32'h0);
    chk("bus_timeout", {31'h0, bus_timeout}, {31'h0, tmo});
  endtask

  task automatic model_step();
    bit r0, r1, rsp;
    if (!reset) begin
      mo = -1; mage = 0; last_m1 = 1'b1;
      return;
    end
    if (mo < 0) begin
      r0 = mrd[0] || mwr[0];
      r1 = mrd[1] || mwr[1];
      if (r0 && r1) mo = last_m1 ? 0 : 1;
      else if (r0) mo = 0;
      else if (r1) mo = 1;
      if (mo >= 0) begin
        mtr = mrd[mo];
        mage = 1;
        lat = $urandom_range(0, 9);
      end
    end else begin
      rsp = srr || swr;
      if (rsp || (TE && mage == TMO)) begin
        done[mo] = 1'b1;
        last_m1 = (mo == 1);
        mo = -1;
      end else begin
        mage++;
      end
    end
  endtask

  task automatic drive_auto();
    for (int k = 0; k < 2; k++) begin
      if (done[k] || !(mrd[k] || mwr[k])) begin
        done[k] = 1'b0;
        ma[k] = $urandom; md[k] = $urandom;
        ms[k] = 4'($urandom);
        if ($urandom_range(0, 2) == 0) begin
          mrd[k] = 1'($urandom_range(0, 1));
          mwr[k] = !mrd[k];
        end else begin
          mrd[k] = 1'b0; mwr[k] = 1'b0;
        end
      end
    end
    srd = $urandom;
    srr = 1'b0; swr = 1'b0;
    if (mo >= 0) begin
      if (mage == lat + 1) begin
        srr = mtr; swr = !mtr;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      srr = 1'($urandom_range(0, 1));
      swr = !srr;
    end
  endtask

  task automatic neg();
    @(negedge clock);
    if (auto_mode) drive_auto();
  endtask

  task automatic settle();
    #1 compare();
  endtask

  task automatic pos();
    @(posedge clock);
    model_step();
  endtask

  task automatic cyc();
    neg(); settle(); pos();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      ma[k] = '0; md[k] = '0; ms[k] = '0;
      mrd[k] = 1'b0; mwr[k] = 1'b0; done[k] = 1'b0;
    end
    srr = 1'b0; swr = 1'b0; srd = '0;
    repeat (3) cyc();

    // Idle after reset release, with a stray response that must be ignored.
    for (int i = 0; i < 10; i++) begin
      neg();
      reset = 1'b1;
      srr = (i == 4);
      srd = 32'h12345678;
      settle();
      chk("idle_grant", {30'h0, grant}, 32'h0);
      chk("idle_sreq", {31'h0, s_read_request | s_write_request}, 32'h0);
      chk("idle_m0rresp", {31'h0, m0_read_response}, 32'h0);
      chk("idle_tmo", {31'h0, bus_timeout}, 32'h0);
      pos();
    end
    srr = 1'b0;

    // Both managers write continuously: grants alternate starting with m0.
    for (int i = 0; i < 6; i++) begin
      neg();
      mwr[0] = 1'b1; ms[0] = 4'b1100; md[0] = 32'hA0A0_0000 + i;
      mwr[1] = 1'b1; ms[1] = 4'b0011; md[1] = 32'hB1B1_0000 + i;
      swr = 1'b0;
      settle();
      chk("rr_idle_grant", {30'h0, grant}, 32'h0);
      pos();
      neg(); settle();
      chk("rr_grant", {30'h0, grant}, (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_strobe", {28'h0, s_write_strobe},
          (i % 2 == 0) ? 32'hC : 32'h3);
      pos();
      neg(); swr = 1'b1; settle();
      chk("rr_m0_wresp", {31'h0, m0_write_response},
          (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("rr_m1_wresp", {31'h0, m1_write_response},
          (i % 2 == 0) ? 32'h0 : 32'h1);
      pos();
    end
    neg(); mwr[0] = 1'b0; mwr[1] = 1'b0; swr = 1'b0; settle(); pos();

    // m0 single read answered one cycle after the forwarded request.
    neg(); mrd[0] = 1'b1; ma[0] = 32'h10; settle();
    chk("rd_decide_grant", {30'h0, grant}, 32'h0);
    chk("rd_decide_sreq", {31'h0, s_read_request}, 32'h0);
    pos();
    neg(); settle();
    chk("rd_grant", {30'h0, grant}, 32'h1);
    chk("rd_sreq", {31'h0, s_read_request}, 32'h1);
    chk("rd_addr", s_rw_address, 32'h10);
    pos();
    neg(); srr = 1'b1; srd = 32'hDEADBEEF; settle();
    chk("rd_m0_resp", {31'h0, m0_read_response}, 32'h1);
    chk("rd_m0_data", m0_read_data, 32'hDEADBEEF);
    chk("rd_m1_resp", {31'h0, m1_read_response}, 32'h0);
    chk("rd_m1_data", m1_read_data, 32'h0);
    pos();
    neg(); mrd[0] = 1'b0; srr = 1'b0; settle();
    chk("rd_after_grant", {30'h0, grant}, 32'h0);
    pos();

    // Reset pulse while m1 write is in flight.
    neg(); mwr[1] = 1'b1; ma[1] = 32'h40; ms[1] = 4'hF; settle(); pos();
    neg(); settle();
    chk("rst_pre_grant", {30'h0, grant}, 32'h2);
    pos();
    neg(); reset = 1'b0; swr = 1'b1; settle();
    chk("rst_grant", {30'h0, grant}, 32'h0);
    chk("rst_swreq", {31'h0, s_write_request}, 32'h0);
    chk("rst_addr", s_rw_address, 32'h0);
    chk("rst_m1_wresp", {31'h0, m1_write_response}, 32'h0);
    pos();
    neg(); reset = 1'b1; mwr[1] = 1'b0; swr = 1'b0; settle(); pos();
    neg(); mrd[0] = 1'b1; ma[0] = 32'h80; settle(); pos();
    neg(); settle();
    chk("post_rst_grant", {30'h0, grant}, 32'h1);
    pos();
    neg(); srr = 1'b1; srd = 32'h0BAD_F00D; settle();
    chk("post_rst_resp", {31'h0, m0_read_response}, 32'h1);
    chk("post_rst_data", m0_read_data, 32'h0BAD_F00D);
    pos();
    neg(); mrd[0] = 1'b0; srr = 1'b0; settle(); pos();

`ifdef RVSTEEL_BUS_ARBITER_TIMEOUT_EN
    // m1 read with a silent subordinate times out on the 8th BUSY cycle.
    neg(); mrd[1] = 1'b1; ma[1] = 32'h200; settle(); pos();
    for (int a = 1; a <= TMO; a++) begin
      neg(); srd = 32'h5555_AAAA; settle();
      chk("to_pulse", {31'h0, bus_timeout}, (a == TMO) ? 32'h1 : 32'h0);
      chk("to_m1_rresp", {31'h0, m1_read_response},
          (a == TMO) ? 32'h1 : 32'h0);
      if (a == TMO) chk("to_m1_rdata", m1_read_data, 32'h0);
      pos();
    end
    neg(); mrd[1] = 1'b0; settle();
    chk("to_after_grant", {30'h0, grant}, 32'h0);
    pos();
    // A response on the 8th BUSY cycle beats the timeout.
    neg(); mrd[0] = 1'b1; settle(); pos();
    for (int a = 1; a <= TMO; a++) begin
      neg(); srr = (a == TMO); srd = 32'hCAFEF00D; settle();
      if (a == TMO) begin
        chk("race_resp", {31'h0, m0_read_response}, 32'h1);
        chk("race_data", m0_read_data, 32'hCAFEF00D);
        chk("race_tmo", {31'h0, bus_timeout}, 32'h0);
      end
      pos();
    end
    neg(); mrd[0] = 1'b0; srr = 1'b0; settle(); pos();
`endif

    // Randomized traffic against the model.
    done[0] = 1'b0; done[1] = 1'b0;
    auto_mode = 1'b1;
    repeat (4000) cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/rvsteel_bus_arbiter.md
Name: rvsteel_bus_arbiter

Overview:
Two-manager to one-subordinate arbiter for the RISC-V Steel system bus. It shares a single subordinate (typically the SoC memory) between the CPU manager (m0) and a second manager (m1), such as a UART boot loader or DMA. Arbitration is round-robin, and a grant is held for exactly one complete transaction, request through response. It sits between the managers and the bus mux inside the SoC top.

Parameters:
TIMEOUT_CYCLES, 255, cycles to wait for a subordinate response before forcing an error response (used only with the optional feature; legal range 1..65535)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
m0_rw_address  input  32  manager 0 address
m0_read_data  output  32  manager 0 read data
m0_read_request  input  1  manager 0 read request
m0_read_response  output  1  manager 0 read response, single-cycle pulse
m0_write_data  input  32  manager 0 write data
m0_write_strobe  input  4  manager 0 byte enables
m0_write_request  input  1  manager 0 write request
m0_write_response  output  1  manager 0 write response, single-cycle pulse
m1_*  same eight signals as m0_*, same directions and widths, for manager 1
s_rw_address  output  32  to subordinate
s_read_data  input  32  from subordinate
s_read_request  output  1  to subordinate
s_read_response  input  1  from subordinate
s_write_data  output  32  to subordinate
s_write_strobe  output  4  to subordinate
s_write_request  output  1  to subordinate
s_write_response  input  1  from subordinate
grant  output  2  one-hot current owner; 2'b00 when idle
bus_timeout  output  1  one-cycle pulse when a transaction is aborted by timeout

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE, grant=00, last_owner=m1 (so m0 wins the first tie), timeout counter=0. All s_* request/data/strobe outputs are 0. All m*_response outputs are 0. m*_read_data are 0. bus_timeout=0.
- Reset asserted mid-transaction: the transaction is dropped immediately with no response pulse. After release, arbitration restarts from IDLE.
- A manager is requesting when read_request or write_request is high. A manager holds address, data, strobe and request stable until its response pulse. Asserting read and write together is illegal; if it happens, read has priority.
- States:
  - IDLE: if no manager is requesting, stay. If one is requesting, register a grant to it. If both are requesting, grant the one that is not last_owner. Go to BUSY. The grant decision costs exactly one cycle, so no request is forwarded during IDLE.
  - BUSY: forward the owner's address, data, strobe and requests combinationally to s_*. The non-owner sees responses=0 and read_data=0.
  - BUSY exit: on s_read_response or s_write_response, route the pulse (and s_read_data, same cycle) to the owner only. Then set last_owner=owner, grant=00, and return to IDLE.
- Minimum latency per transaction: 1 arbitration cycle plus the subordinate latency. Back-to-back requests from the same manager therefore see at least one idle cycle between transactions.
- Fairness: with both managers requesting continuously, grants strictly alternate m0, m1, m0, and so on.
- While idle, s_* request outputs are 0. Address, data and strobe are driven 0.
- Any subordinate response arriving in IDLE is ignored and is not routed to either manager.
- A manager that drops its request while in BUSY does not release the grant. The arbiter waits for the subordinate response and discards nothing.

Optional Feature:
RVSTEEL_BUS_ARBITER_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES with no subordinate response, the arbiter returns to IDLE and pulses bus_timeout for one cycle.
  - In that same cycle it gives the owner a response pulse of the requested type, with read_data=32'h00000000.
  - A subordinate response arriving in the same cycle as the timeout wins: it is handled as a normal response and no bus_timeout pulse occurs.
- Not defined: no counter is built, bus_timeout is tied 0, and BUSY waits indefinitely for a response.

Test Plan:
- Reset release, no requests for 10 cycles -> grant=00, all s_* requests 0, no responses, bus_timeout=0.
- m0 reads 32'h00000010, subordinate answers 32'hDEADBEEF one cycle after s_read_request -> grant=01 one cycle after the request. m0_read_response pulses once with m0_read_data=32'hDEADBEEF. m1 sees nothing.
- m0 and m1 both issue writes continuously for 6 transactions -> grant sequence 01,10,01,10,01,10. Each write_response reaches only the owner. s_write_strobe matches the owner's strobe, for example 4'b0011 for m1.
- m1 write in flight (BUSY) and reset pulsed low for 1 cycle -> all outputs 0 immediately, no m1_write_response. After release, a new m0 read completes normally.
- Macro defined, TIMEOUT_CYCLES=8, m1 read with a subordinate that never responds -> bus_timeout and m1_read_response pulse in the same cycle, 8 cycles after BUSY entry, with m1_read_data=0. Next arbitration proceeds normally.
- Macro defined, response arrives exactly on the 8th BUSY cycle -> normal response with the subordinate's data, and bus_timeout stays 0.
